// File: rtl/deposit_ctrl_if.sv
// Credit handshake between deposit_ctrl (master) and the balance keeper (slave).
interface deposit_ctrl_if #(
    parameter int AMT_W = 16
);
    logic             credit_valid;
    logic             credit_ready;
    logic [AMT_W-1:0] credit_amt;

    modport master (
        output credit_valid,
        output credit_amt,
        input  credit_ready
    );

    modport slave (
        input  credit_valid,
        input  credit_amt,
        output credit_ready
    );
endinterface

// File: rtl/deposit_ctrl.sv
// deposit_ctrl: collects notes onto a LIFO stack, credits the sum or ejects all notes on cancel.
// Build macro DEPOSIT_TIMEOUT_EN adds an idle auto-refund after TIMEOUT_CYC cycles in COLLECT.
module deposit_ctrl #(
    parameter int MAX_NOTES   = 8,
    parameter int AMT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_in,
    input  logic [1:0]       note_code,
    input  logic             confirm_button,
    input  logic             cancel_button,
    deposit_ctrl_if.master   credit,
    output logic             eject_valid,
    output logic [1:0]       eject_code,
    output logic             note_accept,
    output logic             note_reject,
    output logic [AMT_W-1:0] deposit_total,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_NOTES + 1);
    localparam int IDX_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NOTES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CREDIT  = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    function automatic logic [AMT_W-1:0] note_value(input logic [1:0] code);
        case (code)
            2'd0:    note_value = AMT_W'(12'd100);
            2'd1:    note_value = AMT_W'(12'd200);
            2'd2:    note_value = AMT_W'(12'd500);
            2'd3:    note_value = AMT_W'(12'd2000);
            default: note_value = '0;
        endcase
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       stack_r [MAX_NOTES];
    logic             note_d_r;
    logic             confirm_d_r;
    logic             cancel_d_r;

    logic             note_ev_s;
    logic             confirm_ev_s;
    logic             cancel_ev_s;
    logic [AMT_W-1:0] val_s;
    logic [AMT_W-1:0] top_val_s;
    logic [AMT_W:0]   sum_s;
    logic             fits_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    assign note_ev_s    = note_in & ~note_d_r;
    assign confirm_ev_s = confirm_button & ~confirm_d_r;
    assign cancel_ev_s  = cancel_button & ~cancel_d_r;
    assign val_s        = note_value(note_code);
    assign push_idx_s   = IDX_W'(count_r);
    assign top_idx_s    = IDX_W'(count_r - CNT_ONE);
    assign top_val_s    = note_value(stack_r[top_idx_s]);
    // One extra bit catches a total that would no longer fit in AMT_W.
    assign sum_s        = {1'b0, deposit_total} + {1'b0, val_s};
    assign fits_s       = ~sum_s[AMT_W];

`ifdef DEPOSIT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);

    logic [TMO_W-1:0] tmo_r;
    logic             tmo_hit_s;

    // Expires on the cycle the counter would reach zero.
    assign tmo_hit_s = (tmo_r <= TMO_ONE);
`else
    logic unused_tmo_s;
    assign unused_tmo_s = |TIMEOUT_CYC;
`endif

    // Session FSM: edge history, note stack, running total and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= ST_IDLE;
            count_r             <= '0;
            note_d_r            <= 1'b0;
            confirm_d_r         <= 1'b0;
            cancel_d_r          <= 1'b0;
            credit.credit_valid <= 1'b0;
            credit.credit_amt   <= '0;
            eject_valid         <= 1'b0;
            eject_code          <= 2'd0;
            note_accept         <= 1'b0;
            note_reject         <= 1'b0;
            deposit_total       <= '0;
            busy                <= 1'b0;
`ifdef DEPOSIT_TIMEOUT_EN
            tmo_r               <= '0;
`endif
        end else begin
            note_d_r    <= note_in;
            confirm_d_r <= confirm_button;
            cancel_d_r  <= cancel_button;
            note_accept <= 1'b0;
            note_reject <= 1'b0;
            eject_valid <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (note_ev_s) begin
                        stack_r[0]    <= note_code;
                        count_r       <= CNT_ONE;
                        deposit_total <= val_s;
                        note_accept   <= 1'b1;
                        state_r       <= ST_COLLECT;
                        busy          <= 1'b1;
`ifdef DEPOSIT_TIMEOUT_EN
                        tmo_r         <= TMO_LOAD;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_COLLECT: begin
`ifdef DEPOSIT_TIMEOUT_EN
                    tmo_r <= tmo_r - TMO_ONE;
`endif
                    if (cancel_ev_s) begin
                        state_r <= ST_REFUND;
                    end else if (confirm_ev_s) begin
                        credit.credit_valid <= 1'b1;
                        credit.credit_amt   <= deposit_total;
                        state_r             <= ST_CREDIT;
`ifdef DEPOSIT_TIMEOUT_EN
                    end else if (tmo_hit_s) begin
                        state_r <= ST_REFUND;
`endif
                    end else if (note_ev_s) begin
                        if ((count_r < CNT_MAX) && fits_s) begin
                            stack_r[push_idx_s] <= note_code;
                            count_r             <= count_r + CNT_ONE;
                            deposit_total       <= sum_s[AMT_W-1:0];
                            note_accept         <= 1'b1;
`ifdef DEPOSIT_TIMEOUT_EN
                            tmo_r               <= TMO_LOAD;
`endif
                        end else begin
                            note_reject <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end

                ST_CREDIT: begin
                    note_reject <= note_ev_s;
                    if (credit.credit_ready) begin
                        credit.credit_valid <= 1'b0;
                        count_r             <= '0;
                        deposit_total       <= '0;
                        state_r             <= ST_IDLE;
                        busy                <= 1'b0;
                    end else begin
                        state_r <= ST_CREDIT;
                    end
                end

                ST_REFUND: begin
                    note_reject   <= note_ev_s;
                    eject_valid   <= 1'b1;
                    eject_code    <= stack_r[top_idx_s];
                    count_r       <= count_r - CNT_ONE;
                    deposit_total <= deposit_total - top_val_s;
                    if (count_r <= CNT_ONE) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_REFUND;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/deposit_ctrl.md
Name: deposit_ctrl

Overview:
Deposit-side counterpart of the ATM withdraw path. Collects inserted notes, keeps a LIFO record of them, and either credits the accumulated sum to the balance keeper through a valid/ready handshake or ejects every note on cancel. Sits between the note-acceptor/button front panel and the balance register, opposite the withdraw decrement path.

Parameters:
MAX_NOTES, 8, depth of the note stack (max notes per deposit session).
AMT_W, 16, width of the amount datapath (unsigned).
TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund (used only with DEPOSIT_TIMEOUT_EN).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
note_in  input  1  note-insert level from acceptor; rising edge = one note.
note_code  input  2  denomination, sampled on the note_in edge: 0=100, 1=200, 2=500, 3=2000.
confirm_button  input  1  confirm level; rising edge = confirm.
cancel_button  input  1  cancel level; rising edge = cancel.
credit_ready  input  1  balance keeper accepts credit.
credit_valid  output  1  credit request pending.
credit_amt  output  AMT_W  amount to credit; stable while credit_valid.
eject_valid  output  1  one-cycle pulse per ejected note.
eject_code  output  2  denomination being ejected; valid with eject_valid.
note_accept  output  1  one-cycle pulse: note stored.
note_reject  output  1  one-cycle pulse: note refused.
deposit_total  output  AMT_W  running session total.
busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; stack count 0; total 0; all outputs 0; edge-detect history regs 0. Reset mid-session discards stored notes without ejecting them.
- Edge detect: event = level & ~previous_level, history registered each cycle. Held levels give exactly one event.
- All outputs registered. An event sampled at edge t produces its response (pulse, total, state change) during cycle t+1.
- States: IDLE, COLLECT, CREDIT, REFUND.
- IDLE: note event -> push code, total = value, note_accept, go COLLECT. Confirm/cancel events ignored.
- COLLECT: priority cancel > confirm > note within one cycle.
  - cancel -> REFUND.
  - confirm -> CREDIT.
  - note -> accept if count < MAX_NOTES and total+value <= 2^AMT_W-1: push, add, note_accept. Otherwise note_reject; total and stack unchanged.
- CREDIT: credit_valid=1, credit_amt=total, both held stable until credit_ready=1 at a clk edge. On that edge: count=0, total=0, credit_valid=0 next cycle, go IDLE. Note events in CREDIT -> note_reject. Cancel/confirm ignored (credit cannot be withdrawn once raised).
- REFUND: each cycle pop top of stack: eject_valid=1, eject_code=top, count-1, total-value. The last pop returns to IDLE, so N notes take N consecutive eject cycles, LIFO order. Notes during REFUND -> note_reject. No backpressure on eject.
- Every COLLECT exit has count >= 1. Credit_valid and eject_valid are never high together.
- busy=1 in COLLECT, CREDIT and REFUND.

Optional Feature:
DEPOSIT_TIMEOUT_EN: when defined, a down-counter is loaded with TIMEOUT_CYC on entry to COLLECT and on every accepted note, and decrements each COLLECT cycle. At 0 the block enters REFUND as if cancelled. A simultaneous confirm event wins over timeout. When undefined, there is no counter and COLLECT waits indefinitely.

Test Plan:
1. Reset. Insert code 2, then code 0, then confirm, with credit_ready=1 -> two note_accept pulses, deposit_total 500 then 600, credit_valid for 1 cycle with credit_amt=600, then IDLE, total 0, busy 0.
2. Insert 9 notes of code 0 (MAX_NOTES=8) -> 8 note_accept, 9th note_reject, deposit_total=800.
3. Insert codes 0,2,3, then cancel -> eject_code 3,2,0 on 3 consecutive cycles; total 2600 -> 600 -> 100 -> 0; IDLE; credit_valid never high.
4. Confirm with credit_ready=0 for 5 cycles, note edge during wait -> credit_valid and credit_amt stable all 5 cycles, note_reject pulse; handshake completes when ready=1.
5. Confirm and cancel rising in the same cycle with 2 notes stored -> REFUND, 2 eject pulses, no credit.
6. rst=1 after the first eject of a 3-note refund -> next cycle all outputs 0, IDLE, no further ejects. With DEPOSIT_TIMEOUT_EN and TIMEOUT_CYC=10: one note, then no activity -> REFUND entered after 10 cycles.
